alu_core: RTL and testbench

//  N-bit integer ALU for the single-cycle ARM-style datapath.

---
 rtl/alu_core.sv | 66 ++++++
 tb/tb_alu_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Integer ALU for the single-cycle datapath: combinational ADD/SUB/AND/OR with NZCV
// flags, plus a flag register loaded on request for the condition logic.
module alu_core #(
  parameter int N_bits = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_bits-1:0] SrcA,
  input  logic [N_bits-1:0] SrcB,
  input  logic [1:0]        ALUControl,
  input  logic              FlagWrite,
  output logic [N_bits-1:0] ALUResult,
  output logic [3:0]        ALUFlags,
  output logic [3:0]        Flags
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Signed overflow: both adder inputs share a sign and the sum's sign differs.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  logic              is_sub;
  logic              is_arith;
  logic [N_bits-1:0] adder_b;
  logic [N_bits:0]   sum;
  logic              flag_n;
  logic              flag_z;
  logic              flag_c;
  logic              flag_v;

  // SUB reuses the adder as SrcA + ~SrcB + 1, so carry-out means "no borrow".
  assign is_sub   = (ALUControl == OP_SUB);
  assign is_arith = (ALUControl == OP_ADD) || (ALUControl == OP_SUB);
  assign adder_b  = is_sub ? ~SrcB : SrcB;
  assign sum      = {1'b0, SrcA} + {1'b0, adder_b} + {{N_bits{1'b0}}, is_sub};

  always_comb begin
    ALUResult = sum[N_bits-1:0];
    case (ALUControl)
      OP_AND:  ALUResult = SrcA & SrcB;
      OP_OR:   ALUResult = SrcA | SrcB;
      default: ALUResult = sum[N_bits-1:0];
    endcase
  end

  assign flag_n   = ALUResult[N_bits-1];
  assign flag_z   = (ALUResult == '0);
  assign flag_c   = is_arith & sum[N_bits];
  assign flag_v   = is_arith & add_ovf(SrcA[N_bits-1], adder_b[N_bits-1], sum[N_bits-1]);
  assign ALUFlags = {flag_n, flag_z, flag_c, flag_v};

  // Stored flags: reset wins over a write request; no bypass to the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (FlagWrite) begin
      Flags <= ALUFlags;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: stimulus queues expected responses, a monitor
// pops and compares them whenever the stimulus strobes a settled output.
module tb_alu_core;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [1:0]   ALUControl;
  logic         FlagWrite;
  logic [W-1:0] ALUResult;
  logic [3:0]   ALUFlags;
  logic [3:0]   Flags;

  alu_core #(.N_bits(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .FlagWrite  (FlagWrite),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags),
    .Flags      (Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;   // 0: combinational result+flags, 1: result only, 2: Flags register
    string        name;
    logic [W-1:0] er;
    logic [3:0]   ef;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic strobe = 1'b0;

  // Monitor: consumes every queued expectation when the stimulus presents output.
  initial begin
    exp_t e;
    forever begin
      @(strobe);
      while (q.size() != 0) begin
        e = q.pop_front();
        if (e.kind == 2) begin
          checks++;
          if (Flags !== e.ef) begin
            errors++;
            $display("FAIL %s: Flags=%b expected %b", e.name, Flags, e.ef);
          end
        end else begin
          checks++;
          if (ALUResult !== e.er) begin
            errors++;
            $display("FAIL %s: ALUResult=%h expected %h", e.name, ALUResult, e.er);
          end
          if (e.kind == 0) begin
            checks++;
            if (ALUFlags !== e.ef) begin
              errors++;
              $display("FAIL %s: ALUFlags=%b expected %b", e.name, ALUFlags, e.ef);
            end
          end
        end
      end
    end
  end

  task automatic present();
    strobe = ~strobe;
    #1;
  endtask

  task automatic comb_check(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] er, input logic [3:0] ef, input string name);
    exp_t e;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    #10;
    e.kind = 0; e.name = name; e.er = er; e.ef = ef;
    q.push_back(e);
    present();
  endtask

  // Drive at the falling edge, check Flags one unit after the rising edge.
  task automatic flag_step(input logic rst, input logic fw, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] ef, input string name);
    exp_t e;
    @(negedge clk);
    reset = rst; FlagWrite = fw; ALUControl = op; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    e.kind = 2; e.name = name; e.er = '0; e.ef = ef;
    q.push_back(e);
    present();
  endtask

  // Reference written from the arithmetic meaning of each flag.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [3:0] f);
    logic [W:0] wide;
    logic       c;
    logic       v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        r    = a + b;
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[W];
        v    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b01: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    f = {r[W-1], (r == '0), c, v};
  endfunction

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [3:0]   f;
    exp_t         e;

    reset = 1'b0; FlagWrite = 1'b0; ALUControl = 2'b00; SrcA = '0; SrcB = '0;

    // Flag register sequence.
    flag_step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 4'b0000, "reset_flags");
    flag_step(1'b0, 1'b1, 2'b01, 32'd5, 32'd5, 4'b0110, "write_5m5");
    flag_step(1'b0, 1'b0, 2'b01, 32'd1, 32'd2, 4'b0110, "hold_no_write");
    // Write request pending but before the edge: stored value must not bypass.
    @(negedge clk);
    FlagWrite = 1'b1; ALUControl = 2'b00; SrcA = 32'h7FFF_FFFF; SrcB = 32'd1;
    #1;
    e.kind = 2; e.name = "no_bypass"; e.er = '0; e.ef = 4'b0110;
    q.push_back(e);
    present();
    @(posedge clk);
    #1;
    e.kind = 2; e.name = "write_ovf"; e.er = '0; e.ef = 4'b1001;
    q.push_back(e);
    present();
    flag_step(1'b1, 1'b1, 2'b01, 32'd1, 32'd2, 4'b0000, "reset_beats_write");
    flag_step(1'b0, 1'b1, 2'b01, 32'd1, 32'd2, 4'b1000, "write_neg");

    @(negedge clk);
    reset = 1'b0; FlagWrite = 1'b0;

    // Directed combinational vectors.
    comb_check(2'b00, 32'd2,          32'd1, 32'd3,          4'b0000, "add_2_1");
    comb_check(2'b01, 32'd2,          32'd1, 32'd1,          4'b0010, "sub_2_1");
    comb_check(2'b01, 32'd5,          32'd5, 32'd0,          4'b0110, "sub_5_5");
    comb_check(2'b01, 32'd1,          32'd2, 32'hFFFF_FFFF,  4'b1000, "sub_1_2");
    comb_check(2'b10, 32'd1,          32'd1, 32'd1,          4'b0000, "and_1_1");
    comb_check(2'b11, 32'd1,          32'd1, 32'd1,          4'b0000, "or_1_1");
    comb_check(2'b00, 32'h7FFF_FFFF,  32'd1, 32'h8000_0000,  4'b1001, "add_ovf");
    comb_check(2'b00, 32'hFFFF_FFFF,  32'd1, 32'd0,          4'b0110, "add_carry");
    comb_check(2'b01, 32'h8000_0000,  32'd1, 32'h7FFF_FFFF,  4'b0011, "sub_ovf");
    comb_check(2'b10, 32'hF0F0_F0F0,  32'h0F0F_0F0F, 32'd0,  4'b0100, "and_zero");
    comb_check(2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, "or_neg");

    // Random operands per opcode against the reference operators.
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 1000; i++) begin
        a = $urandom;
        b = $urandom;
        model(2'(op), a, b, r, f);
        comb_check(2'(op), a, b, r, f, "random");
      end
    end

    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
